// File: rtl/game_sequencer_if.sv
// Player-facing bus of the game sequencer.
//   tick/start/submit/guess : controls from the game board (master drives)
//   target/score/lives/time_left/state/round_win/round_lose : game status (sequencer drives)
interface game_sequencer_if;
  logic       tick;
  logic       start;
  logic       submit;
  logic [7:0] guess;
  logic [7:0] target;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] time_left;
  logic [1:0] state;
  logic       round_win;
  logic       round_lose;

  modport master (
    output tick, start, submit, guess,
    input  target, score, lives, time_left, state, round_win, round_lose
  );

  modport slave (
    input  tick, start, submit, guess,
    output target, score, lives, time_left, state, round_win, round_lose
  );
endinterface

// File: rtl/game_sequencer.sv
// Byte-matching reaction game sequencer.
// The player must set `guess` equal to `target` and submit before the round
// timer (counted in `tick` pulses) runs out. Every SPEEDUP_EVERY consecutive
// wins shortens the round by one tick, down to MIN_TICKS.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : tick/start/submit/guess in; target/score/lives/time_left/
//                  state/round_win/round_lose out (all registered)
module game_sequencer #(
  parameter int ROUND_TICKS   = 10,
  parameter int MIN_TICKS     = 3,
  parameter int SPEEDUP_EVERY = 4,
  parameter int START_LIVES   = 3
) (
  input  logic          clock,
  input  logic          reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, PLAY = 2'b10, OVER = 2'b11} state_t;

  localparam logic [3:0] RT = 4'(ROUND_TICKS);
  localparam logic [3:0] MT = 4'(MIN_TICKS);
  localparam logic [3:0] SE = 4'(SPEEDUP_EVERY);
  localparam logic [1:0] SL = 2'(START_LIVES);

  state_t     st;
  logic [7:0] lfsr, lfsr_nxt;
  logic [7:0] target, score;
  logic [1:0] lives;
  logic [3:0] time_left, round_len, win_count, wc_inc;
  logic       round_win, round_lose, hit;

  // x^8+x^6+x^5+x^4+1, shifting left. A nonzero seed never reaches zero on a
  // maximal-length polynomial; the zero guard just makes that unconditional.
  always_comb begin
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (lfsr_nxt == 8'h00) lfsr_nxt = 8'h01;
  end

  assign hit    = bus.submit && (bus.guess == target);
  assign wc_inc = win_count + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= IDLE;
      lfsr       <= 8'h01;
      target     <= 8'h00;
      score      <= 8'h00;
      lives      <= 2'd0;
      time_left  <= 4'd0;
      round_len  <= RT;
      win_count  <= 4'd0;
      round_win  <= 1'b0;
      round_lose <= 1'b0;
    end else begin
      lfsr       <= lfsr_nxt;
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (bus.start) begin
            score     <= 8'h00;
            lives     <= SL;
            round_len <= RT;
            win_count <= 4'd0;
            st        <= LOAD;
          end
        end
        LOAD: begin
          target    <= lfsr;
          time_left <= round_len;
          st        <= PLAY;
        end
        PLAY: begin
          // A correct submit wins even if a tick lands in the same cycle.
          if (hit) begin
            round_win <= 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
            if (wc_inc == SE) begin
              win_count <= 4'd0;
              if (round_len > MT) round_len <= round_len - 4'd1;
            end else begin
              win_count <= wc_inc;
            end
            st <= LOAD;
          end else if (bus.tick) begin
            if (time_left > 4'd1) begin
              time_left <= time_left - 4'd1;
            end else if (time_left == 4'd1) begin
              time_left  <= 4'd0;
              round_lose <= 1'b1;
              lives      <= lives - 2'd1;
              win_count  <= 4'd0;
              st         <= (lives == 2'd1) ? OVER : LOAD;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.target     = target;
  assign bus.score      = score;
  assign bus.lives      = lives;
  assign bus.time_left  = time_left;
  assign bus.state      = st;
  assign bus.round_win  = round_win;
  assign bus.round_lose = round_lose;
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter ROUND_TICKS, default 10, SHALL be the initial round length in ticks, legal range 1..15.
REQ-003 Parameter MIN_TICKS, default 3, SHALL be the floor for round length, with 1 <= MIN_TICKS <= ROUND_TICKS.
REQ-004 Parameter SPEEDUP_EVERY, default 4, SHALL be the number of consecutive wins between speedups, legal range 1..15.
REQ-005 Parameter START_LIVES, default 3, SHALL be the lives loaded at game start, legal range 1..3.
REQ-006 clock  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 tick  in  1  one-cycle time-base pulse.
REQ-009 start  in  1  one-cycle start pulse, already debounced.
REQ-010 submit  in  1  one-cycle guess-commit pulse.
REQ-011 guess  in  8  player switch value, sampled when submit=1.
REQ-012 target  out  8  current byte the player must match.
REQ-013 score  out  8  rounds won this game.
REQ-014 lives  out  2  remaining lives.
REQ-015 time_left  out  4  ticks remaining in the current round.
REQ-016 state  out  2  current state: IDLE=00, LOAD=01, PLAY=10, OVER=11.
REQ-017 round_win  out  1  one-cycle pulse on a correct submit.
REQ-018 round_lose  out  1  one-cycle pulse on a timeout.

Function
REQ-019 An 8-bit Fibonacci LFSR SHALL:
- use polynomial x^8+x^6+x^5+x^4+1;
- shift every clock in every state;
- never hold 0.
REQ-020 IDLE: start=1 SHALL clear score to 0, load lives=START_LIVES and round_len=ROUND_TICKS, clear win_count, then go to LOAD; all other inputs SHALL be ignored.
REQ-021 LOAD SHALL last exactly one cycle: target<=LFSR value, time_left<=round_len, next state PLAY.
REQ-022 PLAY, submit=1 with guess==target (win):
- round_win=1 for one cycle;
- score+1, saturating at 255;
- win_count+1;
- next state LOAD.
REQ-023 PLAY, submit=1 with guess!=target: no state change, no penalty.
REQ-024 PLAY, tick=1, no win in the same cycle, time_left>1: time_left SHALL decrement by 1.
REQ-025 PLAY, tick=1, no win in the same cycle, time_left==1 (timeout):
- time_left<=0;
- round_lose=1 for one cycle;
- lives-1;
- win_count<=0;
- next state OVER if lives was 1, else LOAD.
REQ-026 Speedup: when a win brings win_count to SPEEDUP_EVERY, win_count SHALL clear to 0 and round_len SHALL decrement by 1, never below MIN_TICKS; the new round_len SHALL apply at the immediately following LOAD.
REQ-027 Simultaneous correct submit and tick in PLAY: the win SHALL take priority; no decrement and no timeout occur.
REQ-028 OVER: score, target and lives=0 SHALL hold; start=1 SHALL behave exactly as in IDLE (new game, then LOAD).
REQ-029 start in LOAD or PLAY SHALL be ignored.
REQ-030 submit and tick in IDLE, LOAD or OVER SHALL be ignored.
REQ-031 round_win and round_lose SHALL never be 1 in the same cycle.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 reset SHALL override all inputs in the cycle it is sampled, including mid-round.
REQ-034 Reset values SHALL be: state=IDLE, target=0, score=0, lives=0, time_left=0, round_win=0, round_lose=0, LFSR=8'h01, round_len=ROUND_TICKS, win_count=0.
REQ-035 Outputs SHALL hold their reset values while reset stays high.

Verification
REQ-036 Reset, start, then submit guess=target:
- LOAD visible one cycle after start, then PLAY with time_left=10, lives=3;
- one cycle after submit: round_win pulse, score=1, then LOAD.
REQ-037 Start, then 10 ticks with no submit:
- time_left counts 10..1, then 0;
- round_lose pulse, lives=2, then LOAD with time_left=10.
REQ-038 Three consecutive timeouts from game start:
- lives 3->2->1->0;
- state OVER, score held;
- start -> score=0, lives=3, LOAD.
REQ-039 Eight consecutive wins with defaults: round_len 10->9 after win 4 and 9->8 after win 8; time_left loads 8 at the next LOAD.
REQ-040 Correct submit and tick asserted together with time_left=1: round_win=1, round_lose=0, lives unchanged.
REQ-041 Reset asserted mid-PLAY with score=5: next cycle all outputs at reset values, LFSR=8'h01.
